// File: rtl/spu_pkg.sv
// spu_pkg: shared widths, default staging depth and the result-staging entry type.
package spu_pkg;
    localparam int REG_ADDR_W = 7;
    localparam int DATA_W     = 128;
    localparam int LAT_W      = 3;
    localparam int PIPE_DEPTH = 7;
    localparam int N_RD       = 6;
    typedef struct packed {
        logic                  valid;
        logic [0:REG_ADDR_W-1] addr;
        logic [0:DATA_W-1]     data;
        logic [0:LAT_W-1]      lat;
    } stage_t;
endpackage

// File: rtl/result_shift_pipe.sv
// result_shift_pipe: one issue pipe's result staging shift register.
// An entry enters at stage 1 and shifts one stage per cycle with no back-pressure.
module result_shift_pipe
    import spu_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [0:REG_ADDR_W-1] in_addr,
    input  logic [0:DATA_W-1]     in_data,
    input  logic [0:LAT_W-1]      in_lat,
    output logic                  lat_err,
    output stage_t [1:DEPTH]      stages
);
    stage_t [1:DEPTH] stage_q, stage_d;
    logic             lat_err_q, lat_err_d;
    // Flush kills whatever moves out of stages 1..DEPTH-1; the stage DEPTH entry has already committed.
    always_comb begin
        stage_d[1] = '{valid: in_valid && (in_lat != '0) && !flush,
                       addr: in_addr, data: in_data, lat: in_lat};
        for (int s = 2; s <= DEPTH; s++) begin
            stage_d[s]       = stage_q[s-1];
            stage_d[s].valid = stage_q[s-1].valid && !flush;
        end
        lat_err_d = in_valid && (in_lat == '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= DEPTH; s++) stage_q[s].valid <= 1'b0;
            lat_err_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            lat_err_q <= lat_err_d;
        end
    end
    assign stages  = stage_q;
    assign lat_err = lat_err_q;
endmodule

// File: rtl/result_pipe.sv
// result_pipe: even/odd result staging with register-file write-back and operand forwarding.
module result_pipe
    import spu_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ev_valid,
    input  logic                  od_valid,
    input  logic [0:REG_ADDR_W-1] ev_addr,
    input  logic [0:REG_ADDR_W-1] od_addr,
    input  logic [0:DATA_W-1]     ev_data,
    input  logic [0:DATA_W-1]     od_data,
    input  logic [0:LAT_W-1]      ev_lat,
    input  logic [0:LAT_W-1]      od_lat,
    output logic                  lat_err,
    output logic                  reg_write_en_1,
    output logic                  reg_write_en_2,
    output logic [0:REG_ADDR_W-1] reg_write_addr_1,
    output logic [0:REG_ADDR_W-1] reg_write_addr_2,
    output logic [0:DATA_W-1]     reg_write_data_1,
    output logic [0:DATA_W-1]     reg_write_data_2,
    input  logic [0:REG_ADDR_W-1] reg_read_addr_1,
    input  logic [0:REG_ADDR_W-1] reg_read_addr_2,
    input  logic [0:REG_ADDR_W-1] reg_read_addr_3,
    input  logic [0:REG_ADDR_W-1] reg_read_addr_4,
    input  logic [0:REG_ADDR_W-1] reg_read_addr_5,
    input  logic [0:REG_ADDR_W-1] reg_read_addr_6,
    output logic                  fwd_hit_1,
    output logic                  fwd_hit_2,
    output logic                  fwd_hit_3,
    output logic                  fwd_hit_4,
    output logic                  fwd_hit_5,
    output logic                  fwd_hit_6,
    output logic [0:DATA_W-1]     fwd_data_1,
    output logic [0:DATA_W-1]     fwd_data_2,
    output logic [0:DATA_W-1]     fwd_data_3,
    output logic [0:DATA_W-1]     fwd_data_4,
    output logic [0:DATA_W-1]     fwd_data_5,
    output logic [0:DATA_W-1]     fwd_data_6,
    output logic                  fwd_stall_1,
    output logic                  fwd_stall_2,
    output logic                  fwd_stall_3,
    output logic                  fwd_stall_4,
    output logic                  fwd_stall_5,
    output logic                  fwd_stall_6
);
    stage_t [1:DEPTH]      ev_st, od_st;
    logic                  ev_err, od_err;
    logic [0:REG_ADDR_W-1] rd_addr  [N_RD];
    logic                  found    [N_RD];
    logic                  rdy      [N_RD];
    logic [0:DATA_W-1]     win_data [N_RD];
    logic                  hit_v    [N_RD];
    logic                  stall_v  [N_RD];
    logic [0:DATA_W-1]     data_v   [N_RD];
    result_shift_pipe #(.DEPTH(DEPTH)) u_ev (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(ev_valid), .in_addr(ev_addr),
        .in_data(ev_data), .in_lat(ev_lat), .lat_err(ev_err), .stages(ev_st)
    );
    result_shift_pipe #(.DEPTH(DEPTH)) u_od (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(od_valid), .in_addr(od_addr),
        .in_data(od_data), .in_lat(od_lat), .lat_err(od_err), .stages(od_st)
    );
    assign lat_err = ev_err | od_err;
    assign reg_write_en_1   = ev_st[DEPTH].valid;
    assign reg_write_addr_1 = ev_st[DEPTH].valid ? ev_st[DEPTH].addr : '0;
    assign reg_write_data_1 = ev_st[DEPTH].valid ? ev_st[DEPTH].data : '0;
    assign reg_write_en_2   = od_st[DEPTH].valid;
    assign reg_write_addr_2 = od_st[DEPTH].valid ? od_st[DEPTH].addr : '0;
    assign reg_write_data_2 = od_st[DEPTH].valid ? od_st[DEPTH].data : '0;
    // Scan oldest to youngest so the youngest match overrides; odd after even wins ties.
    always_comb begin
        for (int k = 0; k < N_RD; k++) begin
            found[k]    = 1'b0;
            rdy[k]      = 1'b0;
            win_data[k] = '0;
            for (int s = DEPTH; s >= 1; s--) begin
                if (ev_st[s].valid && ev_st[s].addr == rd_addr[k]) begin
                    found[k]    = 1'b1;
                    rdy[k]      = s >= int'(ev_st[s].lat);
                    win_data[k] = ev_st[s].data;
                end
                if (od_st[s].valid && od_st[s].addr == rd_addr[k]) begin
                    found[k]    = 1'b1;
                    rdy[k]      = s >= int'(od_st[s].lat);
                    win_data[k] = od_st[s].data;
                end
            end
            hit_v[k]   = found[k] && rdy[k];
            stall_v[k] = found[k] && !rdy[k];
            data_v[k]  = hit_v[k] ? win_data[k] : '0;
        end
    end
    assign rd_addr[0] = reg_read_addr_1;
    assign rd_addr[1] = reg_read_addr_2;
    assign rd_addr[2] = reg_read_addr_3;
    assign rd_addr[3] = reg_read_addr_4;
    assign rd_addr[4] = reg_read_addr_5;
    assign rd_addr[5] = reg_read_addr_6;
    assign fwd_hit_1 = hit_v[0];
    assign fwd_hit_2 = hit_v[1];
    assign fwd_hit_3 = hit_v[2];
    assign fwd_hit_4 = hit_v[3];
    assign fwd_hit_5 = hit_v[4];
    assign fwd_hit_6 = hit_v[5];
    assign fwd_stall_1 = stall_v[0];
    assign fwd_stall_2 = stall_v[1];
    assign fwd_stall_3 = stall_v[2];
    assign fwd_stall_4 = stall_v[3];
    assign fwd_stall_5 = stall_v[4];
    assign fwd_stall_6 = stall_v[5];
    assign fwd_data_1 = data_v[0];
    assign fwd_data_2 = data_v[1];
    assign fwd_data_3 = data_v[2];
    assign fwd_data_4 = data_v[3];
    assign fwd_data_5 = data_v[4];
    assign fwd_data_6 = data_v[5];
endmodule

// File: tb/tb_result_pipe.sv
// tb_result_pipe: directed vector table plus hand-written multi-cycle sequences for result_pipe.
module tb_result_pipe;
    localparam logic [127:0] DA = {32{4'hA}};
    localparam logic [127:0] DB = {32{4'hB}};
    localparam logic [127:0] DC = {32{4'hC}};
    localparam logic [127:0] D1 = {16{8'h11}};
    localparam logic [127:0] D2 = {16{8'h22}};
    localparam logic [127:0] D3 = {16{8'h33}};
    localparam logic [127:0] D4 = {16{8'h44}};
    logic clk = 1'b0;
    logic rst, flush, ev_valid, od_valid;
    logic [0:6] ev_addr, od_addr;
    logic [0:127] ev_data, od_data;
    logic [0:2] ev_lat, od_lat;
    logic lat_err, we1, we2;
    logic [0:6] wa1, wa2;
    logic [0:127] wd1, wd2;
    logic [0:6] rd [6];
    logic hit [6];
    logic stall [6];
    logic [0:127] fd [6];
    int applied = 0;
    int miscompares = 0;
    typedef struct {
        logic rst, flush, ev_v; logic [6:0] ev_a; logic [2:0] ev_l; logic [127:0] ev_d;
        logic od_v; logic [6:0] od_a; logic [2:0] od_l; logic [127:0] od_d;
        logic [6:0] rda;
        logic hit, stall; logic [127:0] fd;
        logic we1; logic [6:0] wa1; logic [127:0] wd1;
        logic we2; logic [6:0] wa2; logic [127:0] wd2;
        logic err;
    } vec_t;
    vec_t tbl [12];
    always #5 clk = ~clk;
    result_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .ev_valid(ev_valid), .od_valid(od_valid),
        .ev_addr(ev_addr), .od_addr(od_addr), .ev_data(ev_data), .od_data(od_data),
        .ev_lat(ev_lat), .od_lat(od_lat), .lat_err(lat_err),
        .reg_write_en_1(we1), .reg_write_en_2(we2),
        .reg_write_addr_1(wa1), .reg_write_addr_2(wa2),
        .reg_write_data_1(wd1), .reg_write_data_2(wd2),
        .reg_read_addr_1(rd[0]), .reg_read_addr_2(rd[1]), .reg_read_addr_3(rd[2]),
        .reg_read_addr_4(rd[3]), .reg_read_addr_5(rd[4]), .reg_read_addr_6(rd[5]),
        .fwd_hit_1(hit[0]), .fwd_hit_2(hit[1]), .fwd_hit_3(hit[2]),
        .fwd_hit_4(hit[3]), .fwd_hit_5(hit[4]), .fwd_hit_6(hit[5]),
        .fwd_data_1(fd[0]), .fwd_data_2(fd[1]), .fwd_data_3(fd[2]),
        .fwd_data_4(fd[3]), .fwd_data_5(fd[4]), .fwd_data_6(fd[5]),
        .fwd_stall_1(stall[0]), .fwd_stall_2(stall[1]), .fwd_stall_3(stall[2]),
        .fwd_stall_4(stall[3]), .fwd_stall_5(stall[4]), .fwd_stall_6(stall[5])
    );
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; ev_valid = 1'b0; od_valid = 1'b0;
    endtask
    task automatic set_rd(input logic [6:0] a);
        for (int k = 0; k < 6; k++) rd[k] = a;
    endtask
    task automatic issue_ev(input logic [6:0] a, input logic [127:0] d, input logic [2:0] l);
        ev_valid = 1'b1; ev_addr = a; ev_data = d; ev_lat = l;
    endtask
    task automatic issue_od(input logic [6:0] a, input logic [127:0] d, input logic [2:0] l);
        od_valid = 1'b1; od_addr = a; od_data = d; od_lat = l;
    endtask
    task automatic chk_port(input string tag, input int k, input logic h, input logic st, input logic [127:0] d);
        chk($sformatf("%s p%0d hit", tag, k + 1), 128'(hit[k]), 128'(h));
        chk($sformatf("%s p%0d stall", tag, k + 1), 128'(stall[k]), 128'(st));
        chk($sformatf("%s p%0d data", tag, k + 1), fd[k], d);
    endtask
    task automatic chk_all_ports(input string tag, input logic h, input logic st, input logic [127:0] d);
        for (int k = 0; k < 6; k++) chk_port(tag, k, h, st, d);
    endtask
    task automatic chk_wr(input string tag, input logic e1, input logic [6:0] a1, input logic [127:0] d1,
                          input logic e2, input logic [6:0] a2, input logic [127:0] d2);
        chk({tag, " we1"}, 128'(we1), 128'(e1));
        chk({tag, " wa1"}, 128'(wa1), 128'(a1));
        chk({tag, " wd1"}, wd1, d1);
        chk({tag, " we2"}, 128'(we2), 128'(e2));
        chk({tag, " wa2"}, 128'(wa2), 128'(a2));
        chk({tag, " wd2"}, wd2, d2);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask
    initial begin
        rst = 1'b0; flush = 1'b0; ev_valid = 1'b0; od_valid = 1'b0;
        ev_addr = '0; od_addr = '0; ev_data = '0; od_data = '0; ev_lat = '0; od_lat = '0;
        set_rd(7'd0);
        tbl[0]  = '{1,0,0,0,0,0,  0,0,0,0,  5, 0,0,0,  0,0,0,  0,0,0, 0};
        tbl[1]  = '{0,0,1,5,2,DA, 0,0,0,0,  5, 0,1,0,  0,0,0,  0,0,0, 0};
        tbl[2]  = '{0,0,0,0,0,0,  0,0,0,0,  5, 1,0,DA, 0,0,0,  0,0,0, 0};
        tbl[3]  = '{0,0,0,0,0,0,  0,0,0,0,  5, 1,0,DA, 0,0,0,  0,0,0, 0};
        tbl[4]  = '{0,0,0,0,0,0,  0,0,0,0,  5, 1,0,DA, 0,0,0,  0,0,0, 0};
        tbl[5]  = '{0,0,0,0,0,0,  0,0,0,0,  5, 1,0,DA, 0,0,0,  0,0,0, 0};
        tbl[6]  = '{0,0,0,0,0,0,  0,0,0,0,  5, 1,0,DA, 0,0,0,  0,0,0, 0};
        tbl[7]  = '{0,0,0,0,0,0,  0,0,0,0,  5, 1,0,DA, 1,5,DA, 0,0,0, 0};
        tbl[8]  = '{0,0,0,0,0,0,  0,0,0,0,  5, 0,0,0,  0,0,0,  0,0,0, 0};
        tbl[9]  = '{0,0,1,4,0,DB, 0,0,0,0,  4, 0,0,0,  0,0,0,  0,0,0, 1};
        tbl[10] = '{0,0,0,0,0,0,  0,0,0,0,  4, 0,0,0,  0,0,0,  0,0,0, 0};
        tbl[11] = '{0,0,0,0,0,0,  1,6,1,DC, 6, 1,0,DC, 0,0,0,  0,0,0, 0};
        foreach (tbl[i]) begin
            rst = tbl[i].rst; flush = tbl[i].flush;
            ev_valid = tbl[i].ev_v; ev_addr = tbl[i].ev_a; ev_lat = tbl[i].ev_l; ev_data = tbl[i].ev_d;
            od_valid = tbl[i].od_v; od_addr = tbl[i].od_a; od_lat = tbl[i].od_l; od_data = tbl[i].od_d;
            set_rd(tbl[i].rda);
            tick();
            chk_port($sformatf("v%0d", i), 0, tbl[i].hit, tbl[i].stall, tbl[i].fd);
            chk_wr($sformatf("v%0d", i), tbl[i].we1, tbl[i].wa1, tbl[i].wd1, tbl[i].we2, tbl[i].wa2, tbl[i].wd2);
            chk($sformatf("v%0d lat_err", i), 128'(lat_err), 128'(tbl[i].err));
        end
        // Younger even producer shadows an older, still-pending odd producer.
        do_reset();
        set_rd(7'd9);
        issue_od(7'd9, DB, 3'd7);
        tick();
        chk_all_ports("yng s1", 0, 1, 0);
        issue_ev(7'd9, DC, 3'd1);
        tick();
        chk_all_ports("yng ev", 1, 0, DC);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_port($sformatf("yng t%0d", i), 0, 1, 0, DC);
            chk_wr($sformatf("yng t%0d", i), 0, 0, 0, 0, 0, 0);
        end
        tick();
        chk_port("yng odc", 0, 1, 0, DC);
        chk_wr("yng odc", 0, 0, 0, 1, 9, DB);
        tick();
        chk_port("yng evc", 0, 1, 0, DC);
        chk_wr("yng evc", 1, 9, DC, 0, 0, 0);
        tick();
        chk_port("yng end", 0, 0, 0, 0);
        chk_wr("yng end", 0, 0, 0, 0, 0, 0);
        // Same-cycle even and odd writes to one register.
        do_reset();
        set_rd(7'd3);
        issue_ev(7'd3, DA, 3'd1);
        issue_od(7'd3, DB, 3'd1);
        tick();
        chk_all_ports("tie s1", 1, 0, DB);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_port($sformatf("tie t%0d", i), 0, 1, 0, DB);
        end
        tick();
        chk_port("tie s7", 0, 1, 0, DB);
        chk_wr("tie s7", 1, 3, DA, 1, 3, DB);
        tick();
        chk_wr("tie end", 0, 0, 0, 0, 0, 0);
        // Flush with one entry at the commit stage and two younger in flight.
        do_reset();
        set_rd(7'd10);
        issue_ev(7'd10, D1, 3'd1);
        tick();
        for (int i = 0; i < 4; i++) tick();
        issue_od(7'd11, D2, 3'd1);
        tick();
        issue_ev(7'd12, D3, 3'd1);
        tick();
        rd[0] = 7'd10; rd[1] = 7'd11; rd[2] = 7'd12; rd[3] = 7'd13; rd[4] = 7'd11; rd[5] = 7'd12;
        #1;
        chk_wr("fl pre", 1, 10, D1, 0, 0, 0);
        chk_port("fl pre", 1, 1, 0, D2);
        chk_port("fl pre", 2, 1, 0, D3);
        flush = 1'b1;
        issue_ev(7'd13, D4, 3'd1);
        tick();
        chk_all_ports("fl post", 0, 0, 0);
        chk_wr("fl post", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_wr($sformatf("fl t%0d", i), 0, 0, 0, 0, 0, 0);
        end
        // Zero-latency issue is rejected and never written.
        do_reset();
        set_rd(7'd4);
        issue_ev(7'd4, DB, 3'd0);
        tick();
        chk("lz err", 128'(lat_err), 128'(1));
        chk_port("lz", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("lz err t%0d", i), 128'(lat_err), 128'(0));
            chk_wr($sformatf("lz t%0d", i), 0, 0, 0, 0, 0, 0);
        end
        // Reset in flight with four entries, beating a concurrent bad issue.
        do_reset();
        issue_ev(7'd20, D1, 3'd3);
        issue_od(7'd21, D2, 3'd3);
        tick();
        issue_ev(7'd22, D3, 3'd1);
        issue_od(7'd23, D4, 3'd1);
        tick();
        rd[0] = 7'd20; rd[1] = 7'd21; rd[2] = 7'd22; rd[3] = 7'd23; rd[4] = 7'd22; rd[5] = 7'd23;
        #1;
        chk_port("rs pre", 0, 0, 1, 0);
        chk_port("rs pre", 2, 1, 0, D3);
        chk_port("rs pre", 3, 1, 0, D4);
        rst = 1'b1;
        issue_ev(7'd24, DA, 3'd0);
        tick();
        chk_all_ports("rs post", 0, 0, 0);
        chk_wr("rs post", 0, 0, 0, 0, 0, 0);
        chk("rs err", 128'(lat_err), 128'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_wr($sformatf("rs t%0d", i), 0, 0, 0, 0, 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/result_pipe.md
RESULT_PIPE -- requirements
Module: result_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 7, meaning number of result-staging stages per pipe.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port flush, input, 1, kill of in-flight, uncommitted results.
REQ-005 SHALL have ports ev_valid / od_valid, input, 1 each, even/odd pipe issue strobe.
REQ-006 SHALL have ports ev_addr / od_addr, input, [0:6] each, target register.
REQ-007 SHALL have ports ev_data / od_data, input, [0:127] each, result value.
REQ-008 SHALL have ports ev_lat / od_lat, input, [0:2] each, unit latency, legal 1..7.
REQ-009 SHALL have port lat_err, output, 1, pulse on issue with latency 0.
REQ-010 SHALL have ports reg_write_en_1 / reg_write_en_2, output, 1 each, even/odd write enable to the register file.
REQ-011 SHALL have ports reg_write_addr_1 / reg_write_addr_2, output, [0:6] each.
REQ-012 SHALL have ports reg_write_data_1 / reg_write_data_2, output, [0:127] each.
REQ-013 SHALL have ports reg_read_addr_1..6, input, [0:6] each, operand addresses also sent to the register file.
REQ-014 SHALL have ports fwd_hit_1..6, output, 1 each, forwarded value valid.
REQ-015 SHALL have ports fwd_data_1..6, output, [0:127] each, forwarded value.
REQ-016 SHALL have ports fwd_stall_1..6, output, 1 each, youngest producer not yet ready.

Function
REQ-017 SHALL hold per pipe DEPTH stages s=1..DEPTH, each {valid, addr, data, lat}; all stages shift by one each cycle; no back-pressure.
REQ-018 SHALL capture an issue (x_valid=1, x_lat!=0) into stage 1 at the next edge.
REQ-019 SHALL reject issue with x_lat=0: stage 1 loads invalid, lat_err=1 for one cycle (registered, cycle after issue).
REQ-020 SHALL drive reg_write_en_n = valid of stage DEPTH of its pipe (n=1 even, 2 odd), with addr/data of that stage; addr/data SHALL read 0 when en=0.
REQ-021 SHALL deem an entry ready when its stage index s >= lat.
REQ-022 SHALL, per read port k, search valid entries of both pipes, all stages; the winning match is the lowest s; at equal s, the odd pipe wins.
REQ-023 SHALL set fwd_hit_k=1 and fwd_data_k=winner data when the winner is ready; fwd_stall_k=0.
REQ-024 SHALL set fwd_stall_k=1, fwd_hit_k=0 when the winner is not ready; older ready matches SHALL NOT be forwarded.
REQ-025 SHALL drive fwd_hit_k=0, fwd_stall_k=0, fwd_data_k=0 with no match; forwarding outputs purely combinational from stage state and read addresses.
REQ-026 SHALL on flush clear valid in stages 1..DEPTH-1 of both pipes at the next edge; stage DEPTH entry still commits this cycle; an issue in the flush cycle SHALL be discarded.
REQ-027 SHALL treat same-address results in both pipes at stage DEPTH as two writes; odd (port 2) is architecturally later.

Reset
REQ-028 SHALL, with rst=1 at an edge, clear all valid bits and lat_err; all write/forward outputs 0 the following cycle.
REQ-029 SHALL give rst priority over flush and issue; stage data need not reset.

Structure
REQ-030 SHALL take REG_ADDR_W=7, DATA_W=128, LAT_W=3, DEPTH default and the stage-entry struct from shared package spu_pkg.
REQ-031 SHALL instantiate sub-module result_shift_pipe twice (even, odd); forwarding priority mux stays in result_pipe.

Verification
REQ-032 SHALL cover: even issue addr 5, data 0xA..A, lat 2 -> reg_write_en_1=1, addr 5 exactly DEPTH cycles later; fwd_stall on read addr 5 at s=1, fwd_hit from s=2.
REQ-033 SHALL cover: odd addr 9 lat 7 then next cycle even addr 9 lat 1 -> read 9 hits even data (younger) while odd still stalling older.
REQ-034 SHALL cover: same cycle even and odd to addr 3 -> fwd_data = odd data; both writes at DEPTH, port 2 odd.
REQ-035 SHALL cover: three issues then flush with one entry in stage DEPTH -> only that entry written, no other write enables, all fwd_hit=0 after.
REQ-036 SHALL cover: issue with lat 0 -> lat_err pulse one cycle, no write ever.
REQ-037 SHALL cover: rst asserted mid-flight with 4 entries -> no writes after, all outputs 0 next cycle.
